store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
Narrows 32-bit register data for SB/SH/SW stores into a 32-bit word-addressed data memory. Sub-word stores use a read-modify-write: read the word, merge the byte or halfword lane, write the word back. It is the write-side counterpart of the load-path widening logic. It sits between the CPU datapath store controls and the data memory port.

Parameters:
ADDR_W, 32, byte-address width of addr_i and mem_addr_o
BIG_ENDIAN, 0, 0 = little-endian lane mapping, 1 = big-endian (byte lane index inverted)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active low
req_i  input  1  store request, sampled only in IDLE
size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal
addr_i  input  ADDR_W  byte address of store
data_i  input  32  register data; byte uses [7:0], half uses [15:0]
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse at completion
err_o  output  1  valid with done_o; misaligned or illegal size
mem_addr_o  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_rd_o  output  1  memory read strobe
mem_rdata_i  input  32  read data, valid in cycle after mem_rd_o
mem_wr_o  output  1  memory write strobe
mem_wdata_o  output  32  merged write word

Behaviour:
- Reset (clock edge with rst_i=0): state=IDLE; all outputs and internal regs 0. Reset overrides everything, including mid-operation; an aborted RMW never issues mem_wr_o after the reset edge.
- States: IDLE, READ, MERGE, WRITE, DONE. Outputs are decoded from state and registered request fields (Moore).
- IDLE:
  - req_i=1 latches size, addr, data.
  - Next state: WRITE if word and aligned; READ if byte, or half with addr[0]=0; otherwise DONE with the error flag set.
- READ: mem_rd_o=1, mem_addr_o=aligned addr. Next state MERGE.
- MERGE: capture mem_rdata_i, replace the selected lane, keep the other lanes unchanged. Next state WRITE.
- WRITE: mem_wr_o=1, mem_wdata_o=merged word (or data for SW). Next state DONE.
- DONE: done_o=1, err_o=error flag. Next state IDLE; the error flag clears.
- Latency from the req edge to done_o high:
  - SW: 2 cycles (WRITE, DONE).
  - SB/SH: 4 cycles (READ, MERGE, WRITE, DONE).
  - Error: 1 cycle (DONE); mem_rd_o and mem_wr_o never assert.
- Lane select:
  - Byte lane b = addr[1:0] XOR {2{BIG_ENDIAN}}, occupies bits [8b+7:8b].
  - Half lane h = addr[1] XOR BIG_ENDIAN, occupies bits [16h+15:16h].
- Misaligned cases:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - size 11 is an error.
- req_i outside IDLE is ignored; no queuing. A new request is accepted in the cycle after DONE at the earliest.
- mem_addr_o holds the aligned latched address in all non-IDLE states and is 0 in IDLE. mem_wdata_o is 0 outside WRITE.
- mem_rd_o and mem_wr_o are never high in the same cycle.

Test Plan:
- Memory word[0x10]=0xAABBCCDD; SB addr=0x12 data=0x12345677 -> mem_rd_o in cycle 1, mem_wr_o in cycle 3 with wdata 0xAA77CCDD, done_o in cycle 4, err_o=0.
- Same memory word; SH addr=0x12 data=0xFFFFBEEF -> wdata 0xBEEFCCDD. With BIG_ENDIAN=1 -> wdata 0xAABBBEEF.
- SW addr=0x14 data=0xDEADBEEF -> no mem_rd_o; mem_wr_o in cycle 1 with mem_addr_o=0x14 and wdata 0xDEADBEEF; done_o in cycle 2.
- Misaligned cases, SH addr=0x11 and SW addr=0x16 -> done_o=1 and err_o=1 in cycle 1; mem_rd_o and mem_wr_o stay 0 throughout; memory unchanged.
- SB addr=0x13 with rst_i=0 on the edge ending MERGE -> next cycle state IDLE, busy_o=0, no mem_wr_o; memory still 0xAABBCCDD.
- SB in progress while req_i is held high with SW addr=0x20 -> second request ignored until IDLE; only one write, to 0x10; the SW starts only if req_i is still high in IDLE.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//
// Turns SB/SH/SW stores into 32-bit word writes on a word-addressed data memory.
// Word stores are written straight through. Byte and halfword stores read the
// target word, splice the new lane in, and write the merged word back.
// Misaligned requests and the illegal size code finish at once with err_o set
// and never touch memory.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous reset, active low
//   req_i        store request, only looked at while idle
//   size_i       00 byte, 01 halfword, 10 word, 11 illegal
//   addr_i       byte address of the store
//   data_i       register data (byte in [7:0], halfword in [15:0])
//   busy_o       high whenever an operation is in flight
//   done_o       one-cycle completion pulse
//   err_o        valid with done_o: misaligned access or illegal size
//   mem_addr_o   word-aligned memory address, 0 while idle
//   mem_rd_o     memory read strobe
//   mem_rdata_i  memory read data, valid the cycle after mem_rd_o
//   mem_wr_o     memory write strobe
//   mem_wdata_o  word to write, 0 outside the write cycle
module store_narrow_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;

  // Classification of an incoming request, evaluated on the live inputs in idle.
  logic req_needs_rmw;
  logic req_is_err;

  always_comb begin
    req_needs_rmw = 1'b0;
    req_is_err    = 1'b0;
    unique case (size_i)
      SizeByte: req_needs_rmw = 1'b1;
      SizeHalf: begin
        if (addr_i[0]) req_is_err    = 1'b1;
        else           req_needs_rmw = 1'b1;
      end
      SizeWord: req_is_err = (addr_i[1:0] != 2'b00);
      default:  req_is_err = 1'b1;
    endcase
  end

  // Lane selection; big-endian mode simply mirrors the lane index.
  logic [1:0] byte_lane;
  logic       half_lane;

  assign byte_lane = addr_q[1:0] ^ {2{BIG_ENDIAN}};
  assign half_lane = addr_q[1] ^ BIG_ENDIAN;

  // Read word with the addressed lane replaced; every other lane passes through.
  logic [31:0] merged;

  always_comb begin
    merged = mem_rdata_i;
    if (size_q == SizeByte) begin
      unique case (byte_lane)
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (half_lane) begin
      merged[31:16] = data_q[15:0];
    end else begin
      merged[15:0] = data_q[15:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    word_d  = word_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          size_d = size_i;
          addr_d = addr_i;
          data_d = data_i;
          if (req_is_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (req_needs_rmw) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StRead: state_d = StMerge;
      StMerge: begin
        word_d  = merged;
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; the reset also kills any half-finished read-modify-write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      size_q  <= 2'b00;
      addr_q  <= '0;
      data_q  <= 32'h0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_addr_o  = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_wdata_o = 32'h0;

    if (state_q != StIdle) begin
      busy_o     = 1'b1;
      mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    end

    unique case (state_q)
      StRead: mem_rd_o = 1'b1;
      StWrite: begin
        mem_wr_o    = 1'b1;
        mem_wdata_o = (size_q == SizeWord) ? data_q : word_q;
      end
      StDone: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  logic        be_busy, be_done, be_err, be_mem_rd, be_mem_wr;
  logic [31:0] be_mem_addr, be_mem_wdata;

  int checks = 0;
  int errors = 0;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .size_i(size), .addr_i(addr), .data_i(data),
    .busy_o(busy), .done_o(done), .err_o(err), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
    .mem_rdata_i(mem_rdata), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata)
  );

  // Big-endian twin sees the same stimulus and read data; only its write word is checked.
  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_dut_be (
    .clk_i(clk), .rst_i(rst), .req_i(req), .size_i(size), .addr_i(addr), .data_i(data),
    .busy_o(be_busy), .done_o(be_done), .err_o(be_err), .mem_addr_o(be_mem_addr),
    .mem_rd_o(be_mem_rd), .mem_rdata_i(mem_rdata), .mem_wr_o(be_mem_wr),
    .mem_wdata_o(be_mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on the strobe, plus a preset port for the bench.
  logic [31:0] mem [64];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        preset_req = 1'b0;
  logic [5:0]  preset_idx = 6'd0;
  logic [31:0] preset_val = 32'h0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr[7:2]];
      rd_cnt = rd_cnt + 1;
    end
    if (mem_wr) begin
      mem[mem_addr[7:2]] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (preset_req) mem[preset_idx] = preset_val;
  end

  // Read and write strobes must never coincide.
  always @(negedge clk) begin
    checks = checks + 1;
    if ((mem_rd && mem_wr) !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rd_wr_overlap: rd=%b wr=%b, required not both 1", mem_rd, mem_wr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mem_set(input logic [5:0] idx, input logic [31:0] val);
    preset_idx = idx;
    preset_val = val;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
  endtask

  // Presents one request for a single edge; returns at the sample point of cycle 1.
  task automatic start(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    size = s;
    addr = a;
    data = d;
    req  = 1'b1;
    tick();
    req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 1'b0;
    size = 2'b00;
    addr = 32'h0;
    data = 32'h0;
    tick();
    tick();
    checks = checks + 1;
    if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, err, mem_rd, mem_wr});
    end
    checks = checks + 1;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    mem_set(6'd4, 32'hAABBCCDD);
    start(2'b00, 32'h12, 32'h12345677);
    checks = checks + 1;
    if ({busy, mem_rd, mem_wr} !== 3'b110 || mem_addr !== 32'h10) begin
      errors = errors + 1;
      $display("FAIL sb_read: busy/rd/wr=%b addr=%h, required 110 addr 10",
               {busy, mem_rd, mem_wr}, mem_addr);
    end
    tick();
    checks = checks + 1;
    if ({mem_rd, mem_wr, done} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL sb_merge: rd/wr/done=%b, required 000", {mem_rd, mem_wr, done});
    end
    tick();
    checks = checks + 1;
    if (mem_wr !== 1'b1 || mem_wdata !== 32'hAA77CCDD || mem_addr !== 32'h10) begin
      errors = errors + 1;
      $display("FAIL sb_write: wr=%b wdata=%h addr=%h, required 1 AA77CCDD 10",
               mem_wr, mem_wdata, mem_addr);
    end
    checks = checks + 1;
    if (be_mem_wr !== 1'b1 || be_mem_wdata !== 32'hAABB77DD) begin
      errors = errors + 1;
      $display("FAIL sb_write_be: wr=%b wdata=%h, required 1 AABB77DD", be_mem_wr, be_mem_wdata);
    end
    tick();
    checks = checks + 1;
    if ({done, err, mem_wr} !== 3'b100 || mem[4] !== 32'hAA77CCDD) begin
      errors = errors + 1;
      $display("FAIL sb_done: done/err/wr=%b mem=%h, required 100 AA77CCDD",
               {done, err, mem_wr}, mem[4]);
    end
    tick();
    checks = checks + 1;
    if ({busy, done} !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL sb_idle: busy/done=%b, required 00", {busy, done});
    end
  endtask

  task automatic test_sh();
    mem_set(6'd4, 32'hAABBCCDD);
    start(2'b01, 32'h12, 32'hFFFFBEEF);
    tick();
    tick();
    checks = checks + 1;
    if (mem_wr !== 1'b1 || mem_wdata !== 32'hBEEFCCDD) begin
      errors = errors + 1;
      $display("FAIL sh_write: wr=%b wdata=%h, required 1 BEEFCCDD", mem_wr, mem_wdata);
    end
    checks = checks + 1;
    if (be_mem_wdata !== 32'hAABBBEEF) begin
      errors = errors + 1;
      $display("FAIL sh_write_be: wdata=%h, required AABBBEEF", be_mem_wdata);
    end
    tick();
    checks = checks + 1;
    if ({done, err} !== 2'b10) begin
      errors = errors + 1;
      $display("FAIL sh_done: done/err=%b, required 10", {done, err});
    end
    tick();
  endtask

  task automatic test_sw();
    int rc;
    rc = rd_cnt;
    start(2'b10, 32'h14, 32'hDEADBEEF);
    checks = checks + 1;
    if ({mem_rd, mem_wr} !== 2'b01 || mem_addr !== 32'h14 || mem_wdata !== 32'hDEADBEEF) begin
      errors = errors + 1;
      $display("FAIL sw_write: rd/wr=%b addr=%h wdata=%h, required 01 14 DEADBEEF",
               {mem_rd, mem_wr}, mem_addr, mem_wdata);
    end
    tick();
    checks = checks + 1;
    if ({done, err} !== 2'b10 || rd_cnt !== rc || mem[5] !== 32'hDEADBEEF) begin
      errors = errors + 1;
      $display("FAIL sw_done: done/err=%b reads=%0d mem=%h, required 10 %0d DEADBEEF",
               {done, err}, rd_cnt - rc, mem[5], 0);
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes [3];
    logic [31:0] addrs [3];
    int          rc, wc;
    sizes[0] = 2'b01; addrs[0] = 32'h11;
    sizes[1] = 2'b10; addrs[1] = 32'h16;
    sizes[2] = 2'b11; addrs[2] = 32'h10;
    mem_set(6'd4, 32'hAABBCCDD);
    for (int i = 0; i < 3; i++) begin
      rc = rd_cnt;
      wc = wr_cnt;
      start(sizes[i], addrs[i], 32'h01020304);
      checks = checks + 1;
      if ({busy, done, err, mem_rd, mem_wr} !== 5'b11100) begin
        errors = errors + 1;
        $display("FAIL misaligned_%0d_done: busy/done/err/rd/wr=%b, required 11100",
                 i, {busy, done, err, mem_rd, mem_wr});
      end
      tick();
      checks = checks + 1;
      if ({busy, done, err} !== 3'b000 || rd_cnt !== rc || wr_cnt !== wc) begin
        errors = errors + 1;
        $display("FAIL misaligned_%0d_after: busy/done/err=%b rd=%0d wr=%0d, required 000 0 0",
                 i, {busy, done, err}, rd_cnt - rc, wr_cnt - wc);
      end
    end
    checks = checks + 1;
    if (mem[4] !== 32'hAABBCCDD) begin
      errors = errors + 1;
      $display("FAIL misaligned_mem: got %h, required AABBCCDD", mem[4]);
    end
  endtask

  task automatic test_reset_abort();
    int wc;
    mem_set(6'd4, 32'hAABBCCDD);
    wc = wr_cnt;
    start(2'b00, 32'h13, 32'h11111199);
    tick();
    rst = 1'b0;
    tick();
    checks = checks + 1;
    if ({busy, mem_wr, done} !== 3'b000 || mem_addr !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL abort_state: busy/wr/done=%b addr=%h, required 000 0",
               {busy, mem_wr, done}, mem_addr);
    end
    rst = 1'b1;
    tick();
    tick();
    tick();
    checks = checks + 1;
    if (wr_cnt !== wc || mem[4] !== 32'hAABBCCDD || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL abort_mem: writes=%0d mem=%h busy=%b, required 0 AABBCCDD 0",
               wr_cnt - wc, mem[4], busy);
    end
  endtask

  task automatic test_back_to_back();
    int wc;
    mem_set(6'd4, 32'hAABBCCDD);
    wc = wr_cnt;
    size = 2'b00;
    addr = 32'h10;
    data = 32'h00000055;
    req  = 1'b1;
    tick();
    // Second request held high while the first is in flight.
    size = 2'b10;
    addr = 32'h20;
    data = 32'hCAFEF00D;
    checks = checks + 1;
    if ({busy, mem_rd} !== 2'b11 || mem_addr !== 32'h10) begin
      errors = errors + 1;
      $display("FAIL b2b_read: busy/rd=%b addr=%h, required 11 10", {busy, mem_rd}, mem_addr);
    end
    tick();
    tick();
    checks = checks + 1;
    if (mem_wr !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hAABBCC55) begin
      errors = errors + 1;
      $display("FAIL b2b_write1: wr=%b addr=%h wdata=%h, required 1 10 AABBCC55",
               mem_wr, mem_addr, mem_wdata);
    end
    tick();
    checks = checks + 1;
    if ({done, err} !== 2'b10) begin
      errors = errors + 1;
      $display("FAIL b2b_done1: done/err=%b, required 10", {done, err});
    end
    tick();
    checks = checks + 1;
    if (busy !== 1'b0 || wr_cnt !== wc + 1) begin
      errors = errors + 1;
      $display("FAIL b2b_idle: busy=%b writes=%0d, required 0 1", busy, wr_cnt - wc);
    end
    tick();
    req = 1'b0;
    checks = checks + 1;
    if (mem_wr !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFEF00D) begin
      errors = errors + 1;
      $display("FAIL b2b_write2: wr=%b addr=%h wdata=%h, required 1 20 CAFEF00D",
               mem_wr, mem_addr, mem_wdata);
    end
    tick();
    tick();
    checks = checks + 1;
    if (wr_cnt !== wc + 2 || mem[8] !== 32'hCAFEF00D || mem[4] !== 32'hAABBCC55) begin
      errors = errors + 1;
      $display("FAIL b2b_mem: writes=%0d m20=%h m10=%h, required 2 CAFEF00D AABBCC55",
               wr_cnt - wc, mem[8], mem[4]);
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_sw();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
